associative_buffer_driver: RTL

Command initiator for the associative buffer on the DE0 board. It debounces five active-low push-button inputs and samples the key/data switches, then issues one register-control command or one read trigger per button press on the buffer's `ctrl`/`key_input`/`data_input`/`trigger_read` inputs. Key and data are held stable between commands, so the buffer sees exactly one access per press and no spurious allocations. The block sits between the board I/O and the buffer at the top level.

---
 rtl/associative_buffer_driver_pkg.sv | 41 ++++
 rtl/associative_buffer_driver_debouncer.sv | 45 ++++
 rtl/associative_buffer_driver.sv | 88 ++++++++
 3 files changed

// File: rtl/associative_buffer_driver_pkg.sv
// Shared constants for the associative buffer command initiator: buffer register
// control encodings, button indices and the command FSM state type.
package associative_buffer_driver_pkg;

    // Buffer register-control encodings, matching the buffer's register.vh.
    localparam int unsigned REG_CTRL_WIDTH = 3;
    localparam logic [REG_CTRL_WIDTH-1:0] REG_CTRL_NOP = 3'd0;
    localparam logic [REG_CTRL_WIDTH-1:0] REG_CTRL_LD  = 3'd1;
    localparam logic [REG_CTRL_WIDTH-1:0] REG_CTRL_INC = 3'd2;
    localparam logic [REG_CTRL_WIDTH-1:0] REG_CTRL_DEC = 3'd3;
    localparam logic [REG_CTRL_WIDTH-1:0] REG_CTRL_CLR = 3'd4;

    localparam int unsigned NUM_BTN = 5;
    localparam logic [2:0] BTN_LD   = 3'd0;
    localparam logic [2:0] BTN_INC  = 3'd1;
    localparam logic [2:0] BTN_DEC  = 3'd2;
    localparam logic [2:0] BTN_CLR  = 3'd3;
    localparam logic [2:0] BTN_READ = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_RELEASE
    } state_t;

    // Lowest set index wins, so LD outranks INC, DEC, CLR and READ.
    function automatic logic [2:0] first_pressed(input logic [NUM_BTN-1:0] p);
        logic [2:0] idx;
        logic       found;
        idx   = BTN_READ;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_BTN; i++) begin
            if (p[i] && !found) begin
                idx   = 3'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/associative_buffer_driver_debouncer.sv
// One push-button channel: two-flop synchronizer, stability counter and a
// registered released-to-pressed pulse. level=1 means pressed.
module debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic async_reset,
    input  logic raw_n,
    output logic level,
    output logic press
);
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_n;
    logic             sync2_n;
    logic             level_d;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!async_reset) begin
            sync1_n <= 1'b1;
            sync2_n <= 1'b1;
            cnt     <= '0;
            level   <= 1'b0;
            level_d <= 1'b0;
            press   <= 1'b0;
        end else begin
            sync1_n <= raw_n;
            sync2_n <= sync1_n;
            level_d <= level;
            press   <= level && !level_d;
            // Any sample agreeing with the accepted level restarts the count.
            if (!sync2_n == level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                cnt   <= '0;
                level <= !sync2_n;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/associative_buffer_driver.sv
// Turns debounced DE0 button presses into single register-control commands or
// read triggers for the associative buffer, with key/data held between presses.
module associative_buffer_driver
    import associative_buffer_driver_pkg::*;
#(
    parameter int unsigned KEY_WIDTH       = 8,
    parameter int unsigned DATA_WIDTH      = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic                      clk,
    input  logic                      async_reset,
    input  logic [KEY_WIDTH-1:0]      key_sw,
    input  logic [DATA_WIDTH-1:0]     data_sw,
    input  logic [NUM_BTN-1:0]        btn_n,
    output logic [REG_CTRL_WIDTH-1:0] ctrl,
    output logic [KEY_WIDTH-1:0]      key_output,
    output logic [DATA_WIDTH-1:0]     data_output,
    output logic                      trigger_read,
    output logic                      busy
);
    logic [NUM_BTN-1:0]    level;
    logic [NUM_BTN-1:0]    press;
    logic [KEY_WIDTH-1:0]  key_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [2:0]            cmd_idx;
    state_t                state;
    state_t                state_next;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debouncer (
            .clk        (clk),
            .async_reset(async_reset),
            .raw_n      (btn_n[i]),
            .level      (level[i]),
            .press      (press[i])
        );
    end

    always_ff @(posedge clk) begin
        if (!async_reset) begin
            state       <= ST_IDLE;
            key_q       <= '0;
            data_q      <= '0;
            key_output  <= '0;
            data_output <= '0;
            cmd_idx     <= BTN_LD;
        end else begin
            state  <= state_next;
            key_q  <= key_sw;
            data_q <= data_sw;
            if (state == ST_IDLE && |press) begin
                key_output  <= key_q;
                data_output <= data_q;
                cmd_idx     <= first_pressed(press);
            end
        end
    end

    always_comb begin
        state_next   = state;
        ctrl         = REG_CTRL_NOP;
        trigger_read = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (|press) state_next = ST_ISSUE;
            end
            ST_ISSUE: begin
                unique case (cmd_idx)
                    BTN_LD:   ctrl = REG_CTRL_LD;
                    BTN_INC:  ctrl = REG_CTRL_INC;
                    BTN_DEC:  ctrl = REG_CTRL_DEC;
                    BTN_CLR:  ctrl = REG_CTRL_CLR;
                    default:  trigger_read = 1'b1;
                endcase
                state_next = ST_WAIT_RELEASE;
            end
            ST_WAIT_RELEASE: begin
                if (level == '0) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign busy = (state != ST_IDLE);

endmodule
